// File: rtl/pattern_stream_gen.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : pattern_stream_gen
// Description : Transmit side of the serial pattern-detect link. On start it
//               emits insert_cnt_i copies of PATTERN (MSB first). Each copy is
//               preceded by gap_i FILL_BIT bits, and PAT_W trailing FILL_BIT
//               bits follow the last copy. The stream can be frozen
//               bit-exactly with pause_i.
// Ports       : clk          rising-edge clock
//               rst          asynchronous reset, active low
//               start_i      start request (sampled only in IDLE)
//               insert_cnt_i number of PATTERN copies (latched on start)
//               gap_i        filler bits before each copy (latched on start)
//               pause_i      freeze the stream while high
//               d_o          serial data bit (registered, 0 when not valid)
//               valid_o      d_o valid this cycle (registered)
//               busy_o       sequence in progress
//               done_o       one-cycle pulse at sequence end
//               sent_cnt_o   PATTERN copies fully emitted in current/last run
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_stream_gen #(
    parameter int               PAT_W    = 5,
    parameter logic [PAT_W-1:0] PATTERN  = 5'b10110,
    parameter logic             FILL_BIT = 1'b0,
    parameter int               CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [CNT_W-1:0] insert_cnt_i,
    input  logic [CNT_W-1:0] gap_i,
    input  logic             pause_i,
    output logic             d_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] sent_cnt_o
);

    localparam int               IDX_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TAIL_LEN = CNT_W'(PAT_W);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        GAP  = 3'd1,
        PAT  = 3'd2,
        TAIL = 3'd3,
        DONE = 3'd4
    } state_t;

    // The state/counter registers name the position of the NEXT bit to emit.
    // A clock edge emits the bit at that position into d_o and advances it,
    // which is what puts the first bit on d_o right after the start edge.
    state_t           state, cur_state, nxt_state;
    logic [CNT_W-1:0] n_lat, g_lat, cnt;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cur_n, cur_g, cur_cnt, cur_sent;
    logic [CNT_W-1:0] nxt_cnt, nxt_sent;
    logic [IDX_W-1:0] cur_idx, nxt_idx;
    logic             launch, nxt_d, nxt_valid, nxt_busy, nxt_done;

    always_comb begin
        launch    = (state == IDLE) && start_i;
        cur_state = state;
        cur_n     = n_lat;
        cur_g     = g_lat;
        cur_cnt   = cnt;
        cur_idx   = idx;
        cur_sent  = sent_cnt_o;

        // A start edge already counts as the first stepping edge, so the
        // starting position is computed from the live inputs here.
        if (launch) begin
            cur_n    = insert_cnt_i;
            cur_g    = gap_i;
            cur_cnt  = '0;
            cur_idx  = IDX_LAST;
            cur_sent = '0;
            if (insert_cnt_i == '0) begin
                cur_state = DONE;
            end else if (gap_i == '0) begin
                cur_state = PAT;
            end else begin
                cur_state = GAP;
            end
        end

        nxt_state = cur_state;
        nxt_cnt   = cur_cnt;
        nxt_idx   = cur_idx;
        nxt_sent  = cur_sent;
        nxt_d     = 1'b0;
        nxt_valid = 1'b0;

        case (cur_state)
            GAP: begin
                if (!pause_i) begin
                    nxt_d     = FILL_BIT;
                    nxt_valid = 1'b1;
                    if ((cur_cnt + CNT_ONE) == cur_g) begin
                        nxt_state = PAT;
                        nxt_cnt   = '0;
                        nxt_idx   = IDX_LAST;
                    end else begin
                        nxt_cnt = cur_cnt + CNT_ONE;
                    end
                end
            end
            PAT: begin
                if (!pause_i) begin
                    nxt_d     = PATTERN[cur_idx];
                    nxt_valid = 1'b1;
                    if (cur_idx == '0) begin
                        nxt_sent = cur_sent + CNT_ONE;
                        nxt_idx  = IDX_LAST;
                        nxt_cnt  = '0;
                        if (nxt_sent == cur_n) begin
                            nxt_state = TAIL;
                        end else if (cur_g == '0) begin
                            nxt_state = PAT;
                        end else begin
                            nxt_state = GAP;
                        end
                    end else begin
                        nxt_idx = cur_idx - IDX_ONE;
                    end
                end
            end
            TAIL: begin
                // Once all tail bits are out this edge only closes the run;
                // no bit is emitted, so pause_i does not stall it.
                if (cur_cnt == TAIL_LEN) begin
                    nxt_state = DONE;
                end else if (!pause_i) begin
                    nxt_d     = FILL_BIT;
                    nxt_valid = 1'b1;
                    nxt_cnt   = cur_cnt + CNT_ONE;
                end
            end
            DONE:    nxt_state = launch ? DONE : IDLE;
            default: nxt_state = IDLE;
        endcase

        nxt_busy = (nxt_state == GAP) || (nxt_state == PAT) || (nxt_state == TAIL);
        nxt_done = (nxt_state == DONE) && (state != DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            n_lat      <= '0;
            g_lat      <= '0;
            cnt        <= '0;
            idx        <= '0;
            sent_cnt_o <= '0;
            d_o        <= 1'b0;
            valid_o    <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            state      <= nxt_state;
            n_lat      <= cur_n;
            g_lat      <= cur_g;
            cnt        <= nxt_cnt;
            idx        <= nxt_idx;
            sent_cnt_o <= nxt_sent;
            d_o        <= nxt_d;
            valid_o    <= nxt_valid;
            busy_o     <= nxt_busy;
            done_o     <= nxt_done;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pattern_stream_gen.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : tb_pattern_stream_gen
// Description : Directed self-checking bench for pattern_stream_gen. It
//               collects the valid bits of each run and compares them with
//               hand-written streams. It also checks latency, pause, restart
//               immunity and asynchronous reset, and runs a loopback against
//               a sliding-window pattern counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_stream_gen;

    localparam int         CNT_W = 8;
    localparam logic [4:0] PAT   = 5'b10110;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] insert_cnt;
    logic [CNT_W-1:0] gap;
    logic             pause;
    logic             d;
    logic             valid;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sent;

    pattern_stream_gen #(
        .PAT_W   (5),
        .PATTERN (PAT),
        .FILL_BIT(1'b0),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .insert_cnt_i(insert_cnt),
        .gap_i       (gap),
        .pause_i     (pause),
        .d_o         (d),
        .valid_o     (valid),
        .busy_o      (busy),
        .done_o      (done),
        .sent_cnt_o  (sent)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-run observations.
    bit q[$];
    int first_at, last_at, done_at, dones, quiet, d_err;
    int busy_at1, busy_at_done, sent_at_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] qval();
        logic [31:0] v = '0;
        foreach (q[i]) v = {v[30:0], q[i]};
        return v;
    endfunction

    // Starts one run and samples every negedge until two cycles after done_o.
    // pause_at/pause_len: raise pause once after that many valid bits.
    // restart_at: cycle at which a stray start pulse is injected (-1: none).
    task automatic run_seq(input string name, input int n, input int g,
                           input int pause_at, input int pause_len, input int restart_at);
        int cyc, pause_left;
        bit pstarted;
        q.delete();
        first_at = -1; last_at = -1; done_at = -1;
        dones = 0; quiet = 0; d_err = 0;
        busy_at1 = 0; busy_at_done = 1; sent_at_done = -1;
        @(negedge clk);
        start      = 1'b1;
        insert_cnt = CNT_W'(n);
        gap        = CNT_W'(g);
        @(negedge clk);
        start      = 1'b0;
        insert_cnt = 8'hAA;
        gap        = 8'h55;
        cyc        = 1;
        pause_left = 0;
        pstarted   = 1'b0;
        while (cyc < 3000) begin
            if (cyc == 1) busy_at1 = int'(busy);
            if (valid) begin
                q.push_back(d);
                if (first_at < 0) first_at = cyc;
                last_at = cyc;
            end else begin
                if (d !== 1'b0) d_err++;
                if (first_at >= 0 && done_at < 0 && !done) quiet++;
            end
            if (done) begin
                dones++;
                if (done_at < 0) begin
                    done_at      = cyc;
                    busy_at_done = int'(busy);
                    sent_at_done = int'(sent);
                end
            end
            start = (cyc == restart_at);
            if (cyc == restart_at) begin
                insert_cnt = 8'd7;
                gap        = 8'd3;
            end
            if (pause_left > 0) begin
                pause_left--;
                if (pause_left == 0) pause = 1'b0;
            end else if (pause_len > 0 && !pstarted && q.size() == pause_at) begin
                pause      = 1'b1;
                pause_left = pause_len;
                pstarted   = 1'b1;
            end
            if (done_at >= 0 && cyc >= done_at + 2) break;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        pause = 1'b0;
        check({name, "_done_seen"}, done_at >= 0, 1);
        check({name, "_done_once"}, dones, 1);
        check({name, "_d_zero_when_idle"}, d_err, 0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int hits, tot_hits, tot_sent, rn, rg;
    logic [4:0] win;

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        insert_cnt = '0;
        gap        = '0;
        pause      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_d", d, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sent", sent, 0);
        rst = 1'b1;

        // n=1, g=0
        run_seq("t1", 1, 0, 0, 0, -1);
        check("t1_len", q.size(), 10);
        check("t1_bits", qval(), 32'b1011000000);
        check("t1_first", first_at, 1);
        check("t1_done_lat", done_at, last_at + 1);
        check("t1_sent", sent_at_done, 1);
        check("t1_busy_run", busy_at1, 1);
        check("t1_busy_done", busy_at_done, 0);
        check("t1_gapless", quiet, 0);

        // n=3, g=2
        run_seq("t2", 3, 2, 0, 0, -1);
        check("t2_len", q.size(), 26);
        check("t2_bits", qval(), 32'b00101100010110001011000000);
        check("t2_first", first_at, 1);
        check("t2_done_lat", done_at, last_at + 1);
        check("t2_sent", sent_at_done, 3);

        // n=0: immediate done, no data
        run_seq("t3", 0, 4, 0, 0, -1);
        check("t3_len", q.size(), 0);
        check("t3_done_lat", done_at, 1);
        check("t3_sent", sent_at_done, 0);
        check("t3_busy_done", busy_at_done, 0);

        // n=2, g=1 with a 3-cycle pause after 3 bits (inside the first copy)
        run_seq("t4", 2, 1, 3, 3, -1);
        check("t4_len", q.size(), 17);
        check("t4_bits", qval(), 32'b01011001011000000);
        check("t4_pause_gap", quiet, 3);
        check("t4_done_lat", done_at, last_at + 1);
        check("t4_sent", sent_at_done, 2);

        // stray start while busy must not disturb the run
        run_seq("t5a", 2, 0, 0, 0, 4);
        check("t5a_len", q.size(), 15);
        check("t5a_bits", qval(), 32'b101101011000000);
        check("t5a_sent", sent_at_done, 2);

        // asynchronous reset in the middle of a pattern
        @(negedge clk);
        start      = 1'b1;
        insert_cnt = 8'd3;
        gap        = 8'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("t5b_valid_before", valid, 1);
        #2 rst = 1'b0;
        #1;
        check("t5b_rst_valid", valid, 0);
        check("t5b_rst_d", d, 0);
        check("t5b_rst_busy", busy, 0);
        check("t5b_rst_done", done, 0);
        check("t5b_rst_sent", sent, 0);
        @(negedge clk);
        rst = 1'b1;
        run_seq("t5c", 1, 0, 0, 0, -1);
        check("t5c_bits", qval(), 32'b1011000000);
        check("t5c_len", q.size(), 10);
        check("t5c_sent", sent_at_done, 1);

        // loopback against a sliding-window detector
        tot_hits = 0;
        tot_sent = 0;
        for (int r = 0; r < 200; r++) begin
            rn = int'($urandom_range(20, 1));
            rg = int'($urandom_range(7, 0));
            run_seq("lb", rn, rg, 0, 0, -1);
            hits = 0;
            win  = '0;
            foreach (q[i]) begin
                win = {win[3:0], q[i]};
                if (i >= 4 && win == PAT) hits++;
            end
            check("lb_hits", hits, sent_at_done);
            check("lb_sent", sent_at_done, rn);
            check("lb_len", q.size(), rn * (rg + 5) + 5);
            tot_hits += hits;
            tot_sent += sent_at_done;
        end
        check("lb_total", tot_hits, tot_sent);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
